seg7_bcd_display: RTL and testbench
===================================

# seg7_bcd_display

Display back end for the LED counter: consumes the free-running 8-bit count and shows it in decimal on a multiplexed 4-digit common-anode seven-segment display. It converts the binary input with a sequential shift-add-3 (double-dabble) engine, holds the result, and scans three digits at a fixed refresh rate. Leading zeros are blanked and the fourth digit is always off.

## Interface
- REFRESH_CYCLE, 50000: clock cycles each digit stays lit. 1 kHz digit rate at 50 MHz. Legal range is 2 to 2^20.
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset. 0 resets the block; release is synchronous to clk in the surrounding design.
- value  in  8  binary count from the counter stage, 0..255. Assumed stable in the clk domain.
- seg  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  out  4  digit anodes, active-low. an[0] is ones, an[1] tens, an[2] hundreds, an[3] unused and always 1.
- bcd  out  12  last completed conversion {hundreds, tens, ones}, 4 bits each.
- busy  out  1  high while a conversion is in progress.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: if value != cap_reg, the block does the following on that edge and stays idle otherwise:
  - cap_reg <= value, sh_reg <= value, work <= 12'h000, bit_cnt <= 0;
  - state <= SHIFT.
- SHIFT, one bit per cycle:
  - first add 3 to each BCD nibble of work that is >= 5;
  - then shift {work, sh_reg} left by 1;
  - bit_cnt increments; after the 8th shift (bit_cnt == 7), state <= DONE.
- DONE: bcd_reg <= work, state <= IDLE.
- busy is 1 in SHIFT and DONE, 0 in IDLE.
- value changes during SHIFT/DONE are ignored. On return to IDLE the mismatch against cap_reg triggers a new conversion. A conversion is never aborted except by reset.
- Width rules: work is 12 bits. The hundreds nibble never exceeds 2, so no overflow handling is needed.
- Scan logic:
  - refresh counter ref_cnt counts 0..REFRESH_CYCLE-1 and wraps;
  - at the wrap, digit index dig advances 0→1→2→0 (value 3 is never reached).
- an and seg are decoded combinationally from dig and bcd_reg only, so they never glitch mid-conversion:
  - an = 1110, 1101 or 1011 for dig 0, 1, 2.
- Segment codes, hex {g..a}, for 0..9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10. Blank is 7F. BCD codes 10..15 cannot occur; if seen, decode them as blank.
- Blanking rules:
  - hundreds is blank if it is 0;
  - tens is blank if hundreds == 0 and tens == 0;
  - ones is never blank.
- bcd output equals bcd_reg.

## Timing
- Reset values:
  - state IDLE, cap_reg 0, bcd_reg 0, ref_cnt 0, dig 0;
  - outputs: busy 0, bcd 12'h000, an 4'b1110, seg 7'h40 (shows "0").
- Latency: with value differing from cap_reg at edge E0, busy rises after E0, SHIFT runs edges E1..E8, DONE at E9, bcd and seg are valid after E9. So 10 cycles from detection to updated output, with busy high for 9 cycles.
- Back-to-back conversions: for a value changing every cycle, the block samples once per 10 cycles. The counter stage changes at 1 Hz, so there are no misses in system use.
- Digit dwell is exactly REFRESH_CYCLE cycles. The full scan period is 3*REFRESH_CYCLE.
- Scanning is independent of conversion and continues while busy.
- rst asserted mid-conversion: everything returns to reset values immediately. After release, a nonzero value is reconverted.

## Test plan
(Use REFRESH_CYCLE=4 in the bench.)
- Reset: rst=0 with value=8'd0, then release. Required: an=1110, seg=40, bcd=000, busy=0. busy stays 0 for 20 cycles and an rotates every 4 cycles: 1110, 1101, 1011, 1110.
- Conversion latency: set value=8'd255. Required: busy high for exactly 9 cycles, bcd=12'h255 on the 10th edge. Scan shows seg 12/12/24 on an 1110/1101/1011.
- Blanking:
  - value=8'd7: bcd=007, seg=78 on ones, 7F on tens and hundreds;
  - value=8'd105: bcd=105, tens shows 40 (not blanked);
  - value=8'd40: hundreds blank, tens 19, ones 40.
- Change during busy: value=8'd10, then value=8'd200 three cycles later. Required: bcd=010 after the first conversion. busy drops for 1 cycle, then rises again, and bcd=200 ten cycles later.
- Reset mid-conversion: value=8'd99, rst=0 at busy cycle 4 for 2 cycles, then released. Required: immediate reset values (bcd=000, busy=0, an=1110). A new conversion starts on the first edge after release and yields bcd=099.
- Sweep: drive value 0..255, waiting for busy=0 each time. bcd must match the decimal digits of value for all 256 codes.

Source files
------------

// File: rtl/seg7_bcd_display.sv
// rtl/seg7_bcd_display.sv - binary-to-BCD converter with 3-digit multiplexed 7-segment scan
module seg7_bcd_display #(
  parameter int REFRESH_CYCLE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int RW = (REFRESH_CYCLE > 1) ? $clog2(REFRESH_CYCLE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    cap_reg;
  logic [7:0]    sh_reg;
  logic [11:0]   work;
  logic [11:0]   work_adj;
  logic [2:0]    bit_cnt;
  logic [11:0]   bcd_reg;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig;
  logic          start;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  assign start    = (value != cap_reg);
  assign work_adj = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
  end

  // Shift-add-3 datapath: adjust nibbles first, then shift {work, sh_reg} left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_reg <= 8'd0;
      sh_reg  <= 8'd0;
      work    <= 12'h000;
      bit_cnt <= 3'd0;
      bcd_reg <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap_reg <= value;
            sh_reg  <= value;
            work    <= 12'h000;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          work    <= {work_adj[10:0], sh_reg[7]};
          sh_reg  <= {sh_reg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        DONE: begin
          bcd_reg <= work;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      dig     <= 2'd0;
    end else if (ref_cnt == RW'(REFRESH_CYCLE - 1)) begin
      ref_cnt <= '0;
      dig     <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  // Display path reads only bcd_reg, so the intermediate work value never shows.
  always_comb begin
    an  = 4'b1111;
    seg = 7'h7F;
    case (dig)
      2'd0: begin
        an  = 4'b1110;
        seg = seg_code(bcd_reg[3:0]);
      end
      2'd1: begin
        an  = 4'b1101;
        seg = (bcd_reg[11:8] == 4'd0 && bcd_reg[7:4] == 4'd0) ? 7'h7F : seg_code(bcd_reg[7:4]);
      end
      2'd2: begin
        an  = 4'b1011;
        seg = (bcd_reg[11:8] == 4'd0) ? 7'h7F : seg_code(bcd_reg[11:8]);
      end
      default: ;
    endcase
  end

  assign bcd = bcd_reg;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb/tb_seg7_bcd_display.sv - directed self-checking bench for seg7_bcd_display
module tb_seg7_bcd_display;

  logic        clk;
  logic        rst;
  logic [7:0]  value;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int total;
  int bad;
  int cyc;
  int cnt;

  seg7_bcd_display #(.REFRESH_CYCLE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // cyc tracks cycles since reset release, giving the expected scan digit.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) cyc = 0;
    else cyc++;
  endtask

  function automatic logic [3:0] an_exp(input int d);
    case (d)
      0:       an_exp = 4'b1110;
      1:       an_exp = 4'b1101;
      default: an_exp = 4'b1011;
    endcase
  endfunction

  task automatic scan(input string tag, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    int d;
    logic [6:0] es;
    for (int i = 0; i < 12; i++) begin
      d  = (cyc / 4) % 3;
      es = (d == 0) ? s0 : (d == 1) ? s1 : s2;
      chk({tag, "_an"}, 32'(an), 32'(an_exp(d)));
      chk({tag, "_seg"}, 32'(seg), 32'(es));
      tick();
    end
  endtask

  task automatic wait_idle();
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd, input string tag);
    value = v;
    tick();
    wait_idle();
    chk(tag, 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [11:0] eb;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    value = 8'd0;
    #1;
    chk("rst_async_an", 32'(an), 32'b1110);
    chk("rst_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_an", 32'(an), 32'(an_exp((i / 4) % 3)));
      tick();
    end

    // Latency: busy high for exactly 9 sampled cycles.
    value = 8'd255;
    tick();
    cnt = 0;
    while (busy && cnt < 30) begin
      cnt++;
      tick();
    end
    chk("lat_busy_cycles", 32'(cnt), 32'd9);
    chk("lat_bcd", 32'(bcd), 32'h255);
    scan("s255", 7'h12, 7'h12, 7'h24);

    convert(8'd7, 12'h007, "bcd7");
    scan("s7", 7'h78, 7'h7F, 7'h7F);
    convert(8'd105, 12'h105, "bcd105");
    scan("s105", 7'h12, 7'h40, 7'h79);
    convert(8'd40, 12'h040, "bcd40");
    scan("s40", 7'h40, 7'h19, 7'h7F);

    // Change during busy is deferred to the next idle cycle.
    value = 8'd10;
    tick();
    tick();
    tick();
    value = 8'd200;
    wait_idle();
    chk("chg_bcd10", 32'(bcd), 32'h010);
    tick();
    chk("chg_rebusy", 32'(busy), 32'd1);
    cnt = 0;
    while (busy && cnt < 30) begin
      cnt++;
      tick();
    end
    chk("chg_busy_cycles", 32'(cnt), 32'd9);
    chk("chg_bcd200", 32'(bcd), 32'h200);

    // Reset at busy cycle 4.
    value = 8'd99;
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bcd), 32'h000);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_an", 32'(an), 32'b1110);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_restart", 32'(busy), 32'd1);
    wait_idle();
    chk("mid_bcd99", 32'(bcd), 32'h099);

    for (int v = 0; v < 256; v++) begin
      eb = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(8'(v), eb, "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
